i2c_slave_ctrl: RTL and testbench

I2C target (slave) controller that responds to a bus master on the same SCL/SDA driver scheme as the team's master bit controller: SDA_oen=1 drives SDA_out, SDA_oen=0 releases the line.
- Detects START, repeated START and STOP conditions.
- Matches a 7-bit address and ACKs matching bytes.
- Delivers received write bytes to the user side and shifts out user-supplied bytes on reads.
- Sits between the pad-level open-drain SDA/SCL buffers and the register/sensor logic it exposes.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_line_sync.sv | 44 ++++
 rtl/i2c_slave_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target controller.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrData,
        StWrAck,
        StRdData,
        StRdAck,
        StWaitStop
    } i2c_state_e;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA and derives SCL edges plus START/STOP conditions.
module i2c_line_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;

    // Reset to the idle bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target: address match, write-byte delivery and read-byte shifting on an
// open-drain SDA (SDA_oen=1 pulls low).
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR    = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL_in,
    input  logic       SDA_in,
    output logic       SDA_out,
    output logic       SDA_oen,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rd_nack,
    output logic       addr_match,
    output logic       busy
);

    logic       scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       sda_oen_q, sda_oen_d;
    logic       addr_match_q, addr_match_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rd_nack_q, rd_nack_d;
    logic       load_tx;
    logic       last_bit;
    logic [7:0] byte_in;

    i2c_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (SCL_in),
        .sda_i     (SDA_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    assign last_bit = (bit_cnt_q == 3'd7);
    assign byte_in  = {shift_q, sda_s};

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        sda_oen_d    = sda_oen_q;
        addr_match_d = addr_match_q;
        busy_d       = busy_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        rd_nack_d    = 1'b0;
        load_tx      = 1'b0;

        if (start_det) begin
            state_d      = StAddr;
            busy_d       = 1'b1;
            addr_match_d = 1'b0;
            bit_cnt_d    = 3'd0;
            sda_oen_d    = 1'b0;
        end else if (stop_det) begin
            state_d      = StIdle;
            busy_d       = 1'b0;
            addr_match_d = 1'b0;
            bit_cnt_d    = 3'd0;
            sda_oen_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StWaitStop: begin
                end
                StAddr: begin
                    if (scl_rise) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            if (shift_q == SLV_ADDR) begin
                                state_d = StAddrAck;
                                rw_d    = sda_s;
                            end else begin
                                state_d = StWaitStop;
                            end
                        end
                    end
                end
                // First fall starts the ACK slot, second fall ends it.
                StAddrAck, StWrAck: begin
                    if (scl_fall) begin
                        if (!sda_oen_q) begin
                            sda_oen_d    = 1'b1;
                            addr_match_d = 1'b1;
                        end else if (state_q == StAddrAck && rw_q == I2C_RW_READ) begin
                            load_tx = 1'b1;
                        end else begin
                            sda_oen_d = 1'b0;
                            state_d   = StWrData;
                        end
                    end
                end
                StWrData: begin
                    if (scl_rise) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            state_d    = StWrAck;
                        end
                    end
                end
                StRdData: begin
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            sda_oen_d = 1'b0;
                            state_d   = StRdAck;
                        end else begin
                            sda_oen_d = ~shift_q[6];
                            shift_d   = {shift_q[5:0], 1'b0};
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise && sda_s != I2C_ACK) begin
                        rd_nack_d = 1'b1;
                        state_d   = StWaitStop;
                    end else if (scl_fall) begin
                        load_tx = 1'b1;
                    end
                end
            endcase
        end

        // Bit 7 goes straight to the pad; the shifter keeps the remaining seven.
        if (load_tx) begin
            shift_d   = tx_data[6:0];
            sda_oen_d = ~tx_data[7];
            bit_cnt_d = 3'd0;
            state_d   = StRdData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            rw_q         <= 1'b0;
            sda_oen_q    <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            rd_nack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            sda_oen_q    <= sda_oen_d;
            addr_match_q <= addr_match_d;
            busy_q       <= busy_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rd_nack_q    <= rd_nack_d;
        end
    end

    assign SDA_out    = 1'b0;
    assign SDA_oen    = sda_oen_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_req     = load_tx & ~rst;
    assign rd_nack    = rd_nack_q;
    assign addr_match = addr_match_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl driving a behavioural open-drain bus master.
module tb_i2c_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       SCL_in, SDA_in;
    logic       SDA_out, SDA_oen, rx_valid, tx_req, rd_nack, addr_match, busy;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0, txr_cnt = 0, nack_cnt = 0, oen_cnt = 0, am_cnt = 0;
    int base_rxv, base_txr, base_nack, base_oen, base_am;
    logic       ack;
    logic       s;
    logic [7:0] d;

    assign SCL_in = scl_m;
    assign SDA_in = sda_m & ~(SDA_oen & ~SDA_out);

    i2c_slave_ctrl #(
        .SLV_ADDR    (7'h42),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SCL_in     (SCL_in),
        .SDA_in     (SDA_in),
        .SDA_out    (SDA_out),
        .SDA_oen    (SDA_oen),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_req     (tx_req),
        .rd_nack    (rd_nack),
        .addr_match (addr_match),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid)   rxv_cnt++;
            if (tx_req)     txr_cnt++;
            if (rd_nack)    nack_cnt++;
            if (SDA_oen)    oen_cnt++;
            if (addr_match) am_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Works from idle (SCL high) and as a repeated START (SCL low).
    task automatic bus_start();
        sda_m = 1'b1;
        wait_n(4);
        scl_m = 1'b1;
        wait_n(8);
        sda_m = 1'b0;
        wait_n(8);
        scl_m = 1'b0;
        wait_n(4);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_n(4);
        scl_m = 1'b1;
        wait_n(4);
        sda_m = 1'b1;
        wait_n(8);
    endtask

    task automatic clock_bit(input logic b, output logic smp);
        sda_m = b;
        wait_n(4);
        scl_m = 1'b1;
        wait_n(4);
        smp = SDA_in;
        wait_n(4);
        scl_m = 1'b0;
        wait_n(4);
    endtask

    task automatic write_byte(input logic [7:0] val, output logic a);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(val[i], dummy);
        clock_bit(1'b1, a);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] val);
        logic dummy;
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, val[i]);
        clock_bit(ack_bit, dummy);
    endtask

    initial begin
        wait_n(4);
        rst = 1'b0;
        wait_n(2);

        // Reset state
        check("rst_sda_oen", SDA_oen, 0);
        check("rst_sda_out", SDA_out, 0);
        check("rst_busy", busy, 0);
        check("rst_addr_match", addr_match, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_rd_nack", rd_nack, 0);

        // Write 0xA5 to 0x42
        base_rxv = rxv_cnt;
        bus_start();
        check("wr_busy_after_start", busy, 1);
        write_byte(8'h84, ack);
        check("wr_addr_ack", ack, 0);
        check("wr_addr_match", addr_match, 1);
        write_byte(8'hA5, ack);
        check("wr_data_ack", ack, 0);
        check("wr_rx_data", rx_data, 8'hA5);
        check("wr_rx_valid_count", rxv_cnt - base_rxv, 1);
        bus_stop();
        check("wr_busy_after_stop", busy, 0);
        check("wr_addr_match_after_stop", addr_match, 0);
        check("wr_sda_released", SDA_oen, 0);

        // Address mismatch
        base_rxv = rxv_cnt;
        base_oen = oen_cnt;
        base_am  = am_cnt;
        bus_start();
        write_byte(8'h86, ack);
        check("mm_addr_nack", ack, 1);
        write_byte(8'h11, ack);
        check("mm_data_nack", ack, 1);
        bus_stop();
        check("mm_oen_never", oen_cnt - base_oen, 0);
        check("mm_addr_match_never", am_cnt - base_am, 0);
        check("mm_rx_valid_never", rxv_cnt - base_rxv, 0);

        // Read 0x3C (ACK) then 0xF0 (NACK)
        tx_data   = 8'h3C;
        base_txr  = txr_cnt;
        base_nack = nack_cnt;
        bus_start();
        write_byte(8'h85, ack);
        check("rd_addr_ack", ack, 0);
        tx_data = 8'hF0;
        read_byte(1'b0, d);
        check("rd_byte0", d, 8'h3C);
        read_byte(1'b1, d);
        check("rd_byte1", d, 8'hF0);
        check("rd_tx_req_count", txr_cnt - base_txr, 2);
        check("rd_nack_count", nack_cnt - base_nack, 1);
        check("rd_sda_released", SDA_oen, 0);
        bus_stop();
        check("rd_busy_after_stop", busy, 0);

        // Repeated START after 4 bits of a write byte
        base_rxv = rxv_cnt;
        bus_start();
        write_byte(8'h84, ack);
        check("rs_addr_ack", ack, 0);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        tx_data = 8'h99;
        bus_start();
        check("rs_no_rx_valid", rxv_cnt - base_rxv, 0);
        check("rs_busy", busy, 1);
        check("rs_addr_match_cleared", addr_match, 0);
        write_byte(8'h85, ack);
        check("rs_read_addr_ack", ack, 0);
        read_byte(1'b1, d);
        check("rs_read_byte", d, 8'h99);
        bus_stop();

        // STOP in the middle of a read byte
        tx_data = 8'h3C;
        bus_start();
        write_byte(8'h85, ack);
        check("sm_addr_ack", ack, 0);
        clock_bit(1'b1, s);
        check("sm_bit7", s, 0);
        clock_bit(1'b1, s);
        check("sm_bit6", s, 0);
        clock_bit(1'b1, s);
        check("sm_bit5", s, 1);
        sda_m = 1'b0;
        wait_n(4);
        scl_m = 1'b1;
        wait_n(4);
        check("sm_busy_before_stop", busy, 1);
        sda_m = 1'b1;
        wait_n(4);
        check("sm_sda_oen", SDA_oen, 0);
        check("sm_busy", busy, 0);
        check("sm_addr_match", addr_match, 0);
        base_oen = oen_cnt;
        for (int i = 0; i < 4; i++) clock_bit(1'b1, s);
        check("sm_idle_no_drive", oen_cnt - base_oen, 0);

        // Reset while driving the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) clock_bit(((8'h84 >> i) & 8'h01) != 0, s);
        sda_m = 1'b1;
        wait_n(4);
        scl_m = 1'b1;
        wait_n(2);
        check("ra_driving_ack", SDA_oen, 1);
        check("ra_addr_match", addr_match, 1);
        rst = 1'b1;
        wait_n(1);
        check("ra_released_on_reset", SDA_oen, 0);
        check("ra_busy_on_reset", busy, 0);
        rst = 1'b0;
        wait_n(2);
        scl_m = 1'b0;
        wait_n(4);
        bus_start();
        write_byte(8'h84, ack);
        check("ra_addr_ack_after_reset", ack, 0);
        write_byte(8'h5A, ack);
        check("ra_data_ack", ack, 0);
        check("ra_rx_data", rx_data, 8'h5A);
        bus_stop();
        check("ra_busy_after_stop", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
